// File: rtl/image_filter3x3_stream.sv
// Streaming 3x3 smooth/sharpen filter over raster-order frames, zero-padded borders.
// Two column-indexed line buffers plus a 3x2 window register; output registered one cycle after each position.
module image_filter3x3_stream #(
   parameter int IMG_W    = 128,
   parameter int IMG_H    = 128,
   parameter int PIX_W    = 8,
   parameter int SM_MUL   = 7,
   parameter int SM_SHIFT = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mode,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_pixel,
   output logic             out_valid,
   output logic [PIX_W-1:0] out_pixel,
   output logic             frame_done
);
   localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int RW   = $clog2(IMG_H + 2);
   localparam int SW   = PIX_W + 4;
   localparam int PW   = SW + $clog2(SM_MUL + 1);
   localparam int HW   = PIX_W + 5;
   localparam int MAXV = (2 ** PIX_W) - 1;

   typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;
   state_t state, state_nx;

   logic [CW-1:0]    pc;
   logic [RW-1:0]    pr;
   logic             mode_q;
   logic [PIX_W-1:0] lb0 [IMG_W];
   logic [PIX_W-1:0] lb1 [IMG_W];
   logic [PIX_W-1:0] win [3][2];
   logic [PIX_W-1:0] col [3];
   logic [PIX_W-1:0] tap [3][3];
   logic             step, last_in, last_pos, have_out;
   logic [PIX_W-1:0] x;
   logic [RW-1:0]    cr;
   logic [CW-1:0]    cc;
   logic [2:0]       vr, vc;
   logic [SW-1:0]    sum;
   logic [PW-1:0]    prod, sm;
   logic [HW-1:0]    sh;
   logic [PIX_W-1:0] res;

   assign last_in  = (pr == RW'(IMG_H - 1)) && (pc == CW'(IMG_W - 1));
   assign last_pos = (pr == RW'(IMG_H + 1)) && (pc == '0);
   assign have_out = (pr >= RW'(2)) || ((pr == RW'(1)) && (pc != '0));

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      step     = 1'b0;
      x        = '0;
      case (state)
         RUN: begin
            in_ready = 1'b1;
            step     = in_valid;
            x        = in_pixel;
            if (in_valid && last_in) state_nx = FLUSH;
         end
         FLUSH: begin
            step = 1'b1;
            if (last_pos) state_nx = DONE;
         end
         DONE:    state_nx = RUN;
         default: state_nx = RUN;
      endcase
   end

   // Centre lags the newest tap by IMG_W+1 positions; masks come from counters only.
   always_comb begin
      if (pc == '0) begin
         cc = CW'(IMG_W - 1);
         cr = pr - RW'(2);
      end else begin
         cc = pc - CW'(1);
         cr = pr - RW'(1);
      end
      vr     = {cr != RW'(IMG_H - 1), 1'b1, cr != '0};
      vc     = {cc != CW'(IMG_W - 1), 1'b1, cc != '0};
      col[0] = lb1[pc];
      col[1] = lb0[pc];
      col[2] = x;
      for (int unsigned k = 0; k < 3; k++) begin
         tap[k][0] = (vr[k] && vc[0]) ? win[k][0] : '0;
         tap[k][1] = (vr[k] && vc[1]) ? win[k][1] : '0;
         tap[k][2] = (vr[k] && vc[2]) ? col[k]    : '0;
      end
   end

   always_comb begin
      sum = '0;
      for (int unsigned k = 0; k < 3; k++)
         for (int unsigned j = 0; j < 3; j++)
            sum = sum + SW'(tap[k][j]);
      prod = PW'(sum) * PW'(SM_MUL);
      sm   = prod >> SM_SHIFT;
      sh   = HW'(tap[1][1]) * HW'(5) - HW'(tap[0][1]) - HW'(tap[2][1])
           - HW'(tap[1][0]) - HW'(tap[1][2]);
      res  = '0;
      if (!mode_q) begin
         res = (sm > PW'(MAXV)) ? '1 : sm[PIX_W-1:0];
      end else if (!sh[HW-1]) begin
         res = (sh > HW'(MAXV)) ? '1 : sh[PIX_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= RUN;
         pc         <= '0;
         pr         <= '0;
         mode_q     <= 1'b0;
         out_valid  <= 1'b0;
         out_pixel  <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nx;
         out_valid  <= 1'b0;
         frame_done <= 1'b0;
         if (state == DONE) begin
            pc <= '0;
            pr <= '0;
         end
         if (step) begin
            if (state == RUN && pr == '0 && pc == '0) mode_q <= mode;
            if (pc == CW'(IMG_W - 1)) begin
               pc <= '0;
               pr <= pr + RW'(1);
            end else begin
               pc <= pc + CW'(1);
            end
            if (have_out) begin
               out_valid  <= 1'b1;
               out_pixel  <= res;
               frame_done <= last_pos;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (step) begin
         lb1[pc] <= lb0[pc];
         lb0[pc] <= x;
         for (int unsigned k = 0; k < 3; k++) begin
            win[k][0] <= win[k][1];
            win[k][1] <= col[k];
         end
      end
   end
endmodule
